uart_cmd_framer: RTL and testbench
==================================

// Module: uart_cmd_framer
// PURPOSE
//  Frames the UART receive byte stream into CR/NL-terminated command packets for the pulse-generator command decoder.
//  Sits between the uart core (received/rx_byte) and the decoder that loads state0/period/eds.
//  Replaces ad-hoc byte buffering with a buffered, handshaked packet interface plus idle timeout.
// PARAMETERS
//  BYTES          16          buffer depth in bytes (payload + CR slot); max payload BYTES-1
//  CR             8'h0d       terminator byte 1
//  NL             8'h0a       terminator byte 2
//  TIMEOUT_CYCLES 50_000_000  sys_clk cycles of rx silence before a partial frame is abandoned
//  LEN_W          $clog2(BYTES+1)  width of frame_len (localparam)
// PORTS
//  sys_clk     in   1        single clock; all logic on posedge
//  rst         in   1        synchronous, active-high reset
//  rx_valid    in   1        1-cycle strobe: rx_byte is valid (uart 'received')
//  rx_byte     in   8        received byte
//  recv_error  in   1        uart framing error strobe
//  frame_valid out  1        packet available; held until accepted
//  frame_ready in   1        decoder accepts packet when frame_valid & frame_ready
//  frame_data  out  8*BYTES  payload; byte i at [8i+7:8i]; bytes >= frame_len are 0
//  frame_len   out  LEN_W    payload length, CR/NL excluded
//  rx_drop     out  1        1-cycle pulse: byte arrived while holding a packet, discarded
//  overflow    out  1        1-cycle pulse: byte arrived with buffer full
//  timeout     out  1        1-cycle pulse: partial frame abandoned by timeout
//  chk_err     out  1        1-cycle pulse: checksum mismatch (0 without FRAMER_CHECKSUM_EN)
// BEHAVIOUR
//  Reset: state IDLE, buffer all 0, idx=0, frame_valid=0, frame_len=0, all pulses 0, timer=0.
//  States: IDLE (empty), COLLECT, HOLD (packet presented), DISCARD (after overflow/error).
//  IDLE/COLLECT, rx_valid: if rx_byte==NL && idx>0 && buf[idx-1]==CR -> buf[idx-1]<=0,
//   frame_len<=idx-1, frame_valid<=1 next cycle (latency 1), ->HOLD.
//   Else if idx==BYTES -> overflow pulse, ->DISCARD. Else buf[idx]<=rx_byte, idx++, ->COLLECT.
//  NL as first byte (idx==0) is payload. Bare CR NL -> frame_len=0 packet, still presented.
//  HOLD: frame_data/frame_len stable; any rx_valid -> rx_drop pulse, byte lost.
//   frame_valid&frame_ready -> buffer cleared, idx=0, frame_valid=0 next cycle, ->IDLE.
//   rx_valid in the accept cycle is dropped (rx_drop pulses).
//  DISCARD: consume bytes, track last byte; CR then NL -> IDLE (no packet, buffer cleared).
//  recv_error in COLLECT/IDLE -> clear buffer, idx=0, ->DISCARD. In HOLD: ignored.
//  Timer: counts sys_clk in COLLECT/DISCARD, cleared on every rx_valid and on state entry;
//   at TIMEOUT_CYCLES-1 -> timeout pulse, buffer cleared, ->IDLE. Not running in IDLE/HOLD.
//  Simultaneous rx_valid and timer expiry: byte wins, timer clears, no timeout.
//  rst mid-frame or in HOLD: everything to reset values next cycle; held packet lost.
//  Buffer clearing is single-cycle (parallel reset of all BYTES registers).
// CONFIGURATION
//  FRAMER_CHECKSUM_EN defined: last payload byte is XOR of all preceding payload bytes.
//   On CR NL: match -> frame_len = payload-1, checksum byte zeroed, packet presented;
//   mismatch or payload length 0 -> chk_err pulse, no packet, ->IDLE. Running XOR updated per byte.
//  Undefined: no checksum logic; full payload presented; chk_err tied 0.
// TESTING  (TIMEOUT_CYCLES=100 in bench)
//  Send 01 10 00 00 00 0D 0A -> 1 cycle after NL frame_valid=1, frame_len=5,
//   frame_data[39:0]=40'h00_0000_1001, rest 0; ready pulse -> frame_valid=0 next cycle.
//  Hold frame_ready=0, send 0x41 -> rx_drop pulse, frame_data unchanged; then accept -> IDLE.
//  Send 17x 0x41 -> overflow pulse after 17th byte; send 0x42 0D 0A -> no frame_valid;
//   then 02 0D 0A -> frame_len=1, byte0=02.
//  Send 01 02 03, silence 100 cycles -> timeout pulse at cycle 100; next 04 0D 0A -> len 1, byte0=04.
//  rst asserted after 01 02 -> all outputs 0; then 07 0D 0A -> len 1, byte0=07.
//  FRAMER_CHECKSUM_EN: 05 AA AF 0D 0A -> len 2, data[15:0]=16'hAA05;
//   05 AA 00 0D 0A -> chk_err pulse, no frame_valid.

Source files
------------

// File: rtl/uart_cmd_framer_if.sv
// Packet-side and receive-side signals of the UART command framer.
// The framer connects through the slave modport; the byte source and decoder use master.
interface uart_cmd_framer_if #(
    parameter int BYTES = 16
);
    localparam int LEN_W = $clog2(BYTES + 1);

    logic                 rx_valid;
    logic [7:0]           rx_byte;
    logic                 recv_error;
    logic                 frame_valid;
    logic                 frame_ready;
    logic [8*BYTES-1:0]   frame_data;
    logic [LEN_W-1:0]     frame_len;
    logic                 rx_drop;
    logic                 overflow;
    logic                 timeout;
    logic                 chk_err;

    modport master (
        output rx_valid, rx_byte, recv_error, frame_ready,
        input  frame_valid, frame_data, frame_len, rx_drop, overflow, timeout, chk_err
    );

    modport slave (
        input  rx_valid, rx_byte, recv_error, frame_ready,
        output frame_valid, frame_data, frame_len, rx_drop, overflow, timeout, chk_err
    );
endinterface

// File: rtl/uart_cmd_framer.sv
// Frames UART rx bytes into CR/NL-terminated packets with handshake, overflow and idle timeout.
// Optional FRAMER_CHECKSUM_EN: trailing payload byte is an XOR checksum, verified and stripped.
module uart_cmd_framer #(
    parameter int         BYTES          = 16,
    parameter logic [7:0] CR             = 8'h0d,
    parameter logic [7:0] NL             = 8'h0a,
    parameter int         TIMEOUT_CYCLES = 50_000_000
) (
    input  logic               sys_clk,
    input  logic               rst,
    uart_cmd_framer_if.slave   fr
);
    localparam int LEN_W = $clog2(BYTES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [7:0]       mem_q [BYTES];
    logic [LEN_W-1:0] idx_q;
    logic [LEN_W-1:0] frame_len_q;
    logic             frame_valid_q;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             last_cr_q;
    logic             rx_drop_q, overflow_q, timeout_q;
    logic             rx_drop_d, overflow_d, timeout_d;
    logic             do_store, do_clear, do_present, is_term, timer_done;
`ifdef FRAMER_CHECKSUM_EN
    logic [7:0]       xsum_q;
    logic             chk_err_q, chk_err_d;
`endif

    assign is_term    = fr.rx_valid && (fr.rx_byte == NL) && last_cr_q;
    assign timer_done = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        timer_d    = '0;
        do_store   = 1'b0;
        do_clear   = 1'b0;
        do_present = 1'b0;
        rx_drop_d  = 1'b0;
        overflow_d = 1'b0;
        timeout_d  = 1'b0;
`ifdef FRAMER_CHECKSUM_EN
        chk_err_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (fr.recv_error) begin
                    do_clear = 1'b1;
                    state_d  = ST_DISCARD;
                end else if (fr.rx_valid) begin
                    if (is_term) begin
`ifdef FRAMER_CHECKSUM_EN
                        // Running XOR includes the stored CR, so a valid payload leaves exactly CR.
                        if (xsum_q == CR && idx_q > LEN_W'(1)) begin
                            do_present = 1'b1;
                            state_d    = ST_HOLD;
                        end else begin
                            chk_err_d = 1'b1;
                            do_clear  = 1'b1;
                            state_d   = ST_IDLE;
                        end
`else
                        do_present = 1'b1;
                        state_d    = ST_HOLD;
`endif
                    end else if (idx_q == LEN_W'(BYTES)) begin
                        overflow_d = 1'b1;
                        state_d    = ST_DISCARD;
                    end else begin
                        do_store = 1'b1;
                        state_d  = ST_COLLECT;
                    end
                end else if (state_q == ST_COLLECT) begin
                    if (timer_done) begin
                        timeout_d = 1'b1;
                        do_clear  = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                rx_drop_d = fr.rx_valid;
                if (frame_valid_q && fr.frame_ready) begin
                    do_clear = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                if (fr.rx_valid) begin
                    if (is_term) begin
                        do_clear = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else if (timer_done) begin
                    timeout_d = 1'b1;
                    do_clear  = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            frame_len_q   <= '0;
            frame_valid_q <= 1'b0;
            timer_q       <= '0;
            last_cr_q     <= 1'b0;
            rx_drop_q     <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
            // NOTE: the buffer is deliberately a resettable register file, not RAM, so it clears in one cycle.
            for (int i = 0; i < BYTES; i++) mem_q[i] <= '0;
`ifdef FRAMER_CHECKSUM_EN
            xsum_q        <= '0;
            chk_err_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rx_drop_q  <= rx_drop_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
`ifdef FRAMER_CHECKSUM_EN
            chk_err_q  <= chk_err_d;
`endif
            if (do_clear) begin
                for (int i = 0; i < BYTES; i++) mem_q[i] <= '0;
                idx_q         <= '0;
                frame_len_q   <= '0;
                frame_valid_q <= 1'b0;
                last_cr_q     <= 1'b0;
`ifdef FRAMER_CHECKSUM_EN
                xsum_q        <= '0;
`endif
            end else begin
                if (fr.rx_valid && state_q != ST_HOLD) last_cr_q <= (fr.rx_byte == CR);
                if (do_store) begin
                    for (int i = 0; i < BYTES; i++)
                        if (i == int'(idx_q)) mem_q[i] <= fr.rx_byte;
                    idx_q <= idx_q + LEN_W'(1);
`ifdef FRAMER_CHECKSUM_EN
                    xsum_q <= xsum_q ^ fr.rx_byte;
`endif
                end else if (do_present) begin
                    frame_valid_q <= 1'b1;
`ifdef FRAMER_CHECKSUM_EN
                    for (int i = 0; i < BYTES; i++)
                        if (i == int'(idx_q) - 1 || i == int'(idx_q) - 2) mem_q[i] <= '0;
                    frame_len_q <= idx_q - LEN_W'(2);
`else
                    for (int i = 0; i < BYTES; i++)
                        if (i == int'(idx_q) - 1) mem_q[i] <= '0;
                    frame_len_q <= idx_q - LEN_W'(1);
`endif
                end
            end
        end
    end

    for (genvar g = 0; g < BYTES; g++) begin : g_data
        assign fr.frame_data[8*g +: 8] = mem_q[g];
    end

    assign fr.frame_valid = frame_valid_q;
    assign fr.frame_len   = frame_len_q;
    assign fr.rx_drop     = rx_drop_q;
    assign fr.overflow    = overflow_q;
    assign fr.timeout     = timeout_q;
`ifdef FRAMER_CHECKSUM_EN
    assign fr.chk_err     = chk_err_q;
`else
    assign fr.chk_err     = 1'b0;
`endif
endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer: queue-based packet model checked every cycle,
// plus literal expectations on the documented vectors.
module tb_uart_cmd_framer;
    localparam int         BYTES = 16;
    localparam int         TO    = 100;
    localparam int         LEN_W = $clog2(BYTES + 1);
    localparam logic [7:0] CR    = 8'h0d;
    localparam logic [7:0] NL    = 8'h0a;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    always #5 sys_clk = ~sys_clk;

    uart_cmd_framer_if #(.BYTES(BYTES)) fr();

    uart_cmd_framer #(
        .BYTES(BYTES), .CR(CR), .NL(NL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .fr(fr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [8*BYTES-1:0] act, input logic [8*BYTES-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the packet in progress is a byte queue; outputs follow from the framing rules.
    typedef enum {M_OPEN, M_HOLD, M_DROP} mode_t;
    mode_t              mode = M_OPEN;
    logic [7:0]         pay[$];
    logic [7:0]         dlast = 8'h00;
    int                 quiet = 0;
    logic               e_valid = 0, e_drop = 0, e_ovf = 0, e_to = 0, e_ck = 0;
    logic [LEN_W-1:0]   e_len = '0;
    logic [8*BYTES-1:0] e_data = '0;
    logic               started = 0;

    task automatic model_present();
        mode    = M_HOLD;
        e_valid = 1'b1;
        e_len   = LEN_W'(pay.size());
        e_data  = '0;
        foreach (pay[i]) e_data[8*i +: 8] = pay[i];
    endtask

    always @(posedge sys_clk) begin
        started = 1'b1;
        e_drop = 0; e_ovf = 0; e_to = 0; e_ck = 0;
        if (rst) begin
            mode = M_OPEN; pay.delete(); quiet = 0; dlast = 8'h00;
            e_valid = 0; e_len = '0; e_data = '0;
        end else begin
            case (mode)
                M_OPEN: begin
                    if (fr.recv_error) begin
                        pay.delete(); mode = M_DROP; dlast = 8'h00; quiet = 0;
                    end else if (fr.rx_valid) begin
                        quiet = 0;
                        if (fr.rx_byte == NL && pay.size() > 0 && pay[$] == CR) begin
                            void'(pay.pop_back());
`ifdef FRAMER_CHECKSUM_EN
                            begin
                                logic [7:0] x;
                                x = 8'h00;
                                foreach (pay[i]) x ^= pay[i];
                                if (pay.size() >= 1 && x == 8'h00) begin
                                    void'(pay.pop_back());
                                    model_present();
                                end else begin
                                    e_ck = 1'b1;
                                    pay.delete();
                                end
                            end
`else
                            model_present();
`endif
                        end else if (pay.size() == BYTES) begin
                            e_ovf = 1'b1; mode = M_DROP; dlast = fr.rx_byte;
                        end else begin
                            pay.push_back(fr.rx_byte);
                        end
                    end else if (pay.size() > 0) begin
                        quiet++;
                        if (quiet == TO) begin
                            e_to = 1'b1; pay.delete(); quiet = 0;
                        end
                    end
                end
                M_HOLD: begin
                    if (fr.rx_valid) e_drop = 1'b1;
                    if (fr.frame_ready) begin
                        mode = M_OPEN; pay.delete(); e_valid = 0; e_len = '0; e_data = '0;
                    end
                end
                default: begin
                    if (fr.rx_valid) begin
                        quiet = 0;
                        if (fr.rx_byte == NL && dlast == CR) begin
                            mode = M_OPEN; pay.delete();
                        end
                        dlast = fr.rx_byte;
                    end else begin
                        quiet++;
                        if (quiet == TO) begin
                            e_to = 1'b1; mode = M_OPEN; pay.delete(); quiet = 0;
                        end
                    end
                end
            endcase
        end
    end

    always @(negedge sys_clk) begin
        if (started) begin
            check("frame_valid", {127'b0, fr.frame_valid}, {127'b0, e_valid});
            check("rx_drop",     {127'b0, fr.rx_drop},     {127'b0, e_drop});
            check("overflow",    {127'b0, fr.overflow},    {127'b0, e_ovf});
            check("timeout",     {127'b0, fr.timeout},     {127'b0, e_to});
            check("chk_err",     {127'b0, fr.chk_err},     {127'b0, e_ck});
            if (e_valid) begin
                check("frame_len",  {{(8*BYTES-LEN_W){1'b0}}, fr.frame_len}, {{(8*BYTES-LEN_W){1'b0}}, e_len});
                check("frame_data", fr.frame_data, e_data);
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        fr.rx_valid = 1'b1;
        fr.rx_byte  = b;
        tick();
        fr.rx_valid = 1'b0;
    endtask

    task automatic accept();
        fr.frame_ready = 1'b1;
        tick();
        fr.frame_ready = 1'b0;
    endtask

    task automatic lit(input string name, input logic [8*BYTES-1:0] act, input logic [8*BYTES-1:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fr.rx_valid = 0; fr.rx_byte = 8'h00; fr.recv_error = 0; fr.frame_ready = 0;
        tick(); tick();
        rst = 1'b0;
        lit("reset_valid", {127'b0, fr.frame_valid}, '0);
        lit("reset_len",   {{(8*BYTES-LEN_W){1'b0}}, fr.frame_len}, '0);
        lit("reset_data",  fr.frame_data, '0);

`ifdef FRAMER_CHECKSUM_EN
        send(8'h05); send(8'haa); send(8'haf); send(CR); send(NL);
        lit("ck_len",    {{(8*BYTES-LEN_W){1'b0}}, fr.frame_len}, 128'd2);
        lit("ck_data",   fr.frame_data, 128'haa05);
        lit("ck_model",  {{(8*BYTES-LEN_W){1'b0}}, e_len}, 128'd2);
        accept();
        send(8'h05); send(8'haa); send(8'h00); send(CR); send(NL);
        lit("ck_bad_err",   {127'b0, fr.chk_err}, 128'd1);
        lit("ck_bad_valid", {127'b0, fr.frame_valid}, 128'd0);
        tick();
        send(CR); send(NL);
        lit("ck_empty_err", {127'b0, fr.chk_err}, 128'd1);
        send(8'h07); send(8'h07); send(CR); send(NL);
        lit("ck_one_data", fr.frame_data, 128'h07);
        accept();
`else
        // Basic frame and hold-state drop
        send(8'h01); send(8'h10); send(8'h00); send(8'h00); send(8'h00); send(CR); send(NL);
        lit("f1_valid", {127'b0, fr.frame_valid}, 128'd1);
        lit("f1_len",   {{(8*BYTES-LEN_W){1'b0}}, fr.frame_len}, 128'd5);
        lit("f1_data",  fr.frame_data, 128'h00_0000_1001);
        lit("f1_model", e_data, 128'h00_0000_1001);
        tick();
        send(8'h41);
        lit("hold_drop", {127'b0, fr.rx_drop}, 128'd1);
        lit("hold_data", fr.frame_data, 128'h00_0000_1001);
        accept();
        lit("f1_accept", {127'b0, fr.frame_valid}, 128'd0);

        // Byte arriving in the accept cycle is dropped
        send(8'h33); send(CR); send(NL);
        fr.frame_ready = 1'b1;
        send(8'h44);
        fr.frame_ready = 1'b0;
        lit("acc_drop",  {127'b0, fr.rx_drop}, 128'd1);
        lit("acc_valid", {127'b0, fr.frame_valid}, 128'd0);

        // Overflow, discard until CR NL, then recover
        for (int i = 0; i < 17; i++) send(8'h41);
        lit("ovf_pulse", {127'b0, fr.overflow}, 128'd1);
        send(8'h42); send(CR); send(NL);
        lit("ovf_novalid", {127'b0, fr.frame_valid}, 128'd0);
        send(8'h02); send(CR); send(NL);
        lit("ovf_rec_len",  {{(8*BYTES-LEN_W){1'b0}}, fr.frame_len}, 128'd1);
        lit("ovf_rec_data", fr.frame_data, 128'h02);
        accept();

        // Maximum payload: 15 bytes plus CR fills the buffer
        for (int i = 0; i < BYTES - 1; i++) send(8'(i + 1));
        send(CR); send(NL);
        lit("max_len", {{(8*BYTES-LEN_W){1'b0}}, fr.frame_len}, 128'd15);
        lit("max_data", fr.frame_data, 128'h000f0e0d0c0b0a090807060504030201);
        accept();

        // Leading NL is payload; bare CR NL gives an empty packet
        send(NL); send(CR); send(NL);
        lit("nl_first", fr.frame_data, 128'h0a);
        accept();
        send(CR); send(NL);
        lit("empty_valid", {127'b0, fr.frame_valid}, 128'd1);
        lit("empty_len",   {{(8*BYTES-LEN_W){1'b0}}, fr.frame_len}, 128'd0);
        accept();

        // Idle timeout fires on the 100th silent cycle
        send(8'h01); send(8'h02); send(8'h03);
        repeat (TO - 1) tick();
        lit("to_early", {127'b0, fr.timeout}, 128'd0);
        tick();
        lit("to_pulse", {127'b0, fr.timeout}, 128'd1);
        send(8'h04); send(CR); send(NL);
        lit("to_rec", fr.frame_data, 128'h04);
        accept();

        // Byte coinciding with expiry wins
        send(8'h01);
        repeat (TO - 1) tick();
        send(8'h05);
        lit("to_race", {127'b0, fr.timeout}, 128'd0);
        send(CR); send(NL);
        lit("to_race_data", fr.frame_data, 128'h0501);
        accept();

        // Framing error discards the partial frame
        send(8'h01); send(8'h02);
        fr.recv_error = 1'b1; tick(); fr.recv_error = 1'b0;
        send(CR); send(NL);
        lit("err_novalid", {127'b0, fr.frame_valid}, 128'd0);
        send(8'h03); send(CR); send(NL);
        lit("err_rec", fr.frame_data, 128'h03);
        accept();
`endif

        // Reset mid-frame and while holding
        send(8'h01); send(8'h02);
        rst = 1'b1; tick(); rst = 1'b0;
        lit("rst_valid", {127'b0, fr.frame_valid}, 128'd0);
        lit("rst_data",  fr.frame_data, '0);
        send(8'h07); send(CR); send(NL);
        lit("rst_rec_len",  {{(8*BYTES-LEN_W){1'b0}}, fr.frame_len}, 128'd1);
        lit("rst_rec_data", fr.frame_data, 128'h07);
        rst = 1'b1; tick(); rst = 1'b0;
        lit("rst_hold", {127'b0, fr.frame_valid}, 128'd0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
